// File: rtl/median_pkg.sv
// Shared types and sizing for the streaming median window controller.
package median_pkg;

  localparam int unsigned IMG_W_DEF = 16;
  localparam int unsigned IMG_H_DEF = 16;
  localparam int unsigned WIN_DEF   = 3;
  localparam int unsigned COL_W     = $clog2(IMG_W_DEF);
  localparam int unsigned ROW_W     = $clog2(IMG_H_DEF);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Number of fully-populated windows in one frame (no border windows).
  function automatic int unsigned win_per_frame(input int unsigned w,
                                                input int unsigned h,
                                                input int unsigned win);
    return (h - win + 1) * (w - win + 1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with enable, synchronous clear and a combinational wrap pulse.
module wrap_counter #(
  parameter  int unsigned MAX = 16,
  localparam int unsigned W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap_c
);

  logic [W-1:0] r_cnt;

  assign o_cnt    = r_cnt;
  assign o_wrap_c = i_en & (r_cnt == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap_c ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Pixel/window sequencer for the streaming median filter.
// Optional stall counter output enabled by MEDIAN_CTRL_STALL_CNT_EN.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned WIN   = WIN_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     lb_shift,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic                     busy,
  output logic                     frame_done
`ifdef MEDIAN_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  state_t        r_state;
  state_t        w_next;
  logic          r_win_valid;
  logic [CW-1:0] r_win_col;
  logic [RW-1:0] r_win_row;
  logic          r_busy;
  logic          r_frame_done;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_clear;
  logic          w_win_load;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_col_wrap;
  logic          w_row_wrap;

  // A pixel may only enter when the window register is free or being drained.
  assign w_in_ready = ((r_state == FILL) || (r_state == RUN)) & (~r_win_valid | win_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_clear    = abort | ((r_state == IDLE) & start);
  assign w_win_load = w_accept & (r_state == RUN) & (w_col >= CW'(WIN - 1));

  assign in_ready   = w_in_ready;
  assign lb_shift   = w_accept;
  assign win_valid  = r_win_valid;
  assign win_col    = r_win_col;
  assign win_row    = r_win_row;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  wrap_counter #(.MAX(IMG_W)) u_col_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_accept),
    .i_clear  (w_clear),
    .o_cnt    (w_col),
    .o_wrap_c (w_col_wrap)
  );

  // Row wrap coincides with acceptance of the frame's last pixel.
  wrap_counter #(.MAX(IMG_H)) u_row_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_col_wrap),
    .i_clear  (w_clear),
    .o_cnt    (w_row),
    .o_wrap_c (w_row_wrap)
  );

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = FILL;
        FILL:    if (w_col_wrap && (w_row == RW'(WIN - 2))) w_next = RUN;
        RUN:     if (w_row_wrap) w_next = DRAIN;
        DRAIN:   if (!r_win_valid || win_ready) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != IDLE);
      r_frame_done <= (w_next == DONE);
    end
  end

  // Window register: a consume and a new load in the same cycle reload without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_col   <= '0;
      r_win_row   <= '0;
    end else if (abort) begin
      r_win_valid <= 1'b0;
    end else if (w_win_load) begin
      r_win_valid <= 1'b1;
      r_win_col   <= w_col;
      r_win_row   <= w_row;
    end else if (r_win_valid && win_ready) begin
      r_win_valid <= 1'b0;
    end
  end

`ifdef MEDIAN_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_clear) begin
      r_stall_cnt <= '0;
    end else if (r_win_valid && !win_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl with a window-coordinate scoreboard.
module tb_median_window_ctrl;

  localparam int unsigned IMG = 16;
  localparam int unsigned WN  = 3;
  localparam int unsigned NWIN = (IMG - WN + 1) * (IMG - WN + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic       in_ready;
  logic       lb_shift;
  logic       win_valid;
  logic [3:0] win_col;
  logic [3:0] win_row;
  logic       busy;
  logic       frame_done;
`ifdef MEDIAN_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  median_window_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lb_shift   (lb_shift),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_col    (win_col),
    .win_row    (win_row),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef MEDIAN_CTRL_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pix   = 0;
  int win_cnt = 0;
  int fd_cnt  = 0;
  int fd_cyc  = 0;
  int last_acc_cyc = 0;
  logic [7:0] first_win = 8'h00;
  logic [7:0] last_win  = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-cycle observation at the falling edge: model pixel stream and check consumed windows.
  task automatic monitor();
    logic [7:0] e;
    int r;
    int c;
    if (!rst_n) begin
      exp_q.delete();
      pix = 0;
      win_cnt = 0;
      return;
    end
    if (!busy) chk("in_ready_idle", 32'(in_ready), 32'd0);
    chk("lb_shift", 32'(lb_shift), 32'(in_valid & in_ready));
    if (in_valid && in_ready) begin
      r = pix / IMG;
      c = pix % IMG;
      if (r >= WN - 1 && c >= WN - 1) exp_q.push_back(8'((r << 4) | c));
      pix++;
      if (pix == IMG * IMG) last_acc_cyc = cyc;
    end
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) begin
        chk("win_unexpected", 32'({win_row, win_col}), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("win_coord", 32'({win_row, win_col}), 32'(e));
      end
      if (win_cnt == 0) first_win = {win_row, win_col};
      last_win = {win_row, win_col};
      win_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (abort || (start && !busy)) begin
      exp_q.delete();
      pix = 0;
      win_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int fd_before, input int limit);
    int g;
    g = 0;
    while (fd_cnt == fd_before && g < limit) begin
      tick();
      g++;
    end
    chk(tag, 32'(g < limit), 32'd1);
  endtask

  initial begin
    int g;
    int fd0;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_win_coord", 32'({win_row, win_col}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: reset mid-frame
    win_ready = 1'b1;
    in_valid = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    g = 0;
    while (pix < 20 && g < 100) begin tick(); g++; end
    chk("t1_timeout", 32'(g < 100), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t1_busy_after_rst", 32'(busy), 32'd0);
    chk("t1_win_valid_after_rst", 32'(win_valid), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t1_no_frame_done", 32'(fd_cnt), 32'd0);

    // 2: full frame, continuous flow
    in_valid = 1'b1;
    win_ready = 1'b1;
    pulse_start();
    wait_done("t2_timeout", 0, 600);
    chk("t2_win_count", 32'(win_cnt), 32'(NWIN));
    chk("t2_first_win", 32'(first_win), 32'h22);
    chk("t2_last_win", 32'(last_win), 32'hFF);
    chk("t2_fd_latency", 32'(fd_cyc - last_acc_cyc), 32'd2);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_fd_once", 32'(fd_cnt), 32'd1);

    // 3: sorter stall at window (row 4, col 7)
    pulse_start();
    g = 0;
    while (!(win_valid && win_row == 4'd4 && win_col == 4'd7) && g < 200) begin tick(); g++; end
    chk("t3_timeout", 32'(g < 200), 32'd1);
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_in_ready_stall", 32'(in_ready), 32'd0);
      chk("t3_win_hold", 32'({win_valid, win_row, win_col}), 32'h147);
      tick();
    end
    win_ready = 1'b1;
    wait_done("t3_timeout_done", 1, 600);
    chk("t3_win_count", 32'(win_cnt), 32'(NWIN));
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef MEDIAN_CTRL_STALL_CNT_EN
    tick();
    chk("t6_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // 4: abort with simultaneous start at pixel 100
    pulse_start();
`ifdef MEDIAN_CTRL_STALL_CNT_EN
    chk("t6_stall_clear", 32'(stall_cnt), 32'd0);
`endif
    g = 0;
    while (pix < 100 && g < 200) begin tick(); g++; end
    chk("t4_timeout", 32'(g < 200), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_win_valid", 32'(win_valid), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    repeat (5) tick();
    chk("t4_no_frame_done", 32'(fd_cnt), 32'd2);
    chk("t4_still_idle", 32'(busy), 32'd0);

    // 5: random gaps with ignored start pulses while busy
    fd0 = fd_cnt;
    pulse_start();
    g = 0;
    while (fd_cnt == fd0 && g < 4000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      win_ready = ($urandom_range(0, 3) != 0);
      start     = (pix < 200) && ($urandom_range(0, 15) == 0);
      tick();
      g++;
    end
    start = 1'b0;
    chk("t5_timeout", 32'(g < 4000), 32'd1);
    chk("t5_win_count", 32'(win_cnt), 32'(NWIN));
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t5_fd_count", 32'(fd_cnt), 32'(fd0 + 1));
    in_valid = 1'b0;
    tick();
    chk("t5_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
